// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register with DEPTH slots that carries a control and a data bundle.
// A slot with valid=0 always has its control bits at 0, so a bubble can never write
// memory or the register file. The ready chain is combinational and there is no skid
// buffer. flush turns every slot into a bubble and drops the op offered on the input.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   asynchronous, active-low; clears valid, ctrl, data and occupancy
//   in_valid   in   upstream presents an op
//   in_ready   out  slot 0 can accept this cycle (combinational)
//   in_ctrl    in   control bundle of the incoming op
//   in_data    in   data bundle of the incoming op
//   flush      in   squash all slots and the incoming op
//   out_valid  out  last slot holds a valid op
//   out_ready  in   downstream accepts; 0 stalls the stage
//   out_ctrl   out  control of the last slot; 0 whenever out_valid=0
//   out_data   out  data of the last slot; meaningless when out_valid=0
//   occupancy  out  number of valid slots (registered)
module pipe_stage_elastic #(
  parameter int unsigned CTRL_W = 5,
  parameter int unsigned DATA_W = 134,
  parameter int unsigned DEPTH  = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [DEPTH-1:0][CTRL_W-1:0] ctrl_q,  ctrl_d;
  logic [DEPTH-1:0][DATA_W-1:0] data_q,  data_d;
  logic [OCC_W-1:0]             occ_q,   occ_d;
  logic [DEPTH:0]               rdy_c;
  logic                         accept_c;

  // Slot i may load when it, or any slot after it, is empty, or when downstream accepts.
  always_comb begin : ready_chain
    logic acc;
    acc          = out_ready;
    rdy_c[DEPTH] = out_ready;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      acc      = acc | ~valid_q[i];
      rdy_c[i] = acc;
    end
  end

  assign in_ready = rdy_c[0] & ~flush;
  assign accept_c = in_valid & in_ready;

  // Next slot contents: shift where ready, hold where stalled, clear valid/ctrl on flush.
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    occ_d   = '0;
    if (flush) begin
      valid_d = '0;
      ctrl_d  = '0;
    end else begin
      if (rdy_c[0]) begin
        valid_d[0] = accept_c;
        ctrl_d[0]  = accept_c ? in_ctrl : '0;
        data_d[0]  = in_data;
      end
      for (int i = 1; i < int'(DEPTH); i++) begin
        if (rdy_c[i]) begin
          // Predecessor ctrl is already 0 when it is empty, so bubbles stay clean.
          valid_d[i] = valid_q[i-1];
          ctrl_d[i]  = ctrl_q[i-1];
          data_d[i]  = data_q[i-1];
        end
      end
    end
    for (int i = 0; i < int'(DEPTH); i++) begin
      occ_d = occ_d + OCC_W'(valid_d[i]);
    end
  end

  // Slot and occupancy registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      ctrl_q  <= '0;
      data_q  <= '0;
      occ_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
      occ_q   <= occ_d;
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_ctrl  = ctrl_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign occupancy = occ_q;

  // An empty output slot must never present active control bits.
  a_ctrl_implies_valid : assert property (
    @(posedge clock) disable iff (!reset) (out_ctrl != '0) |-> out_valid
  );

endmodule
